// File: rtl/frogger_input_pkg.sv
// Shared types and key codes for the Frogger keyboard input path.
// Direction encoding doubles as the move-queue payload.
package frogger_input_pkg;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    localparam logic [7:0] KEY_W_CODE = 8'h1A;
    localparam logic [7:0] KEY_S_CODE = 8'h16;
    localparam logic [7:0] KEY_A_CODE = 8'h04;
    localparam logic [7:0] KEY_D_CODE = 8'h07;

    // Fixed priority: up > down > left > right.
    function automatic dir_t prio_dir(input logic [3:0] req);
        if (req[0])      prio_dir = DIR_UP;
        else if (req[1]) prio_dir = DIR_DOWN;
        else if (req[2]) prio_dir = DIR_LEFT;
        else             prio_dir = DIR_RIGHT;
    endfunction

endpackage

// File: rtl/key_rep_fsm.sv
// Per-direction hold auto-repeat: counts frame ticks after a press and pulses o_rep.
// o_rep is combinational on the tick cycle; no backpressure (events merge downstream).
module key_rep_fsm
    import frogger_input_pkg::*;
#(
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 8,
    parameter int CNT_W         = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_held,
    input  logic i_rise,
    input  logic i_tick,
    output logic o_rep
);

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    rep_state_t       r_state;
    rep_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_rep       = 1'b0;
        // Release wins over a same-cycle tick.
        if (!i_held) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_rise) begin
                        w_state_nxt = DELAY;
                        w_cnt_nxt   = '0;
                    end
                end
                DELAY: begin
                    if (i_tick) begin
                        if (r_cnt == DLY_LAST) begin
                            // With a zero period the key parks here until release.
                            if (REPEAT_PERIOD != 0) begin
                                o_rep       = 1'b1;
                                w_state_nxt = REPEAT;
                                w_cnt_nxt   = '0;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (i_tick) begin
                        if (r_cnt == PER_LAST) begin
                            o_rep     = 1'b1;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/move_fifo.sv
// Synchronous FIFO with flush; no bypass, so a push is visible one edge later.
// Push is accepted when not full, or when full with a same-cycle pop; flush overrides push/pop.
module move_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge Clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
    end

endmodule

// File: rtl/key_move_ctrl.sv
// Keycode word -> queued move commands: match, press edge, auto-repeat, priority arbiter, move FIFO.
// Press reaches move_valid three edges after the keycode change; a full queue parks events in pending.
module key_move_ctrl
    import frogger_input_pkg::*;
#(
    parameter int         SLOTS         = 2,
    parameter logic [7:0] KEY_UP        = KEY_W_CODE,
    parameter logic [7:0] KEY_DOWN      = KEY_S_CODE,
    parameter logic [7:0] KEY_LEFT      = KEY_A_CODE,
    parameter logic [7:0] KEY_RIGHT     = KEY_D_CODE,
    parameter int         REPEAT_DELAY  = 20,
    parameter int         REPEAT_PERIOD = 8,
    parameter int         FIFO_DEPTH    = 4,
    parameter int         CNT_W         = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [8*SLOTS-1:0] keycode,
    input  logic               frame_tick,
    input  logic               clear,
    output logic [3:0]         held,
    output logic               move_valid,
    output logic [1:0]         move_dir,
    input  logic               move_ready,
    output logic [3:0]         last_dir,
    output logic               overflow
);

    logic [3:0] r_held;
    logic [3:0] r_held_d;
    logic [3:0] r_pending;
    logic       r_overflow;
    logic [3:0] r_last_dir;

    logic [7:0] w_slot;
    logic [3:0] w_hit;
    logic [3:0] w_rise;
    logic [3:0] w_rep;
    logic [3:0] w_event;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_grant_vld;
    dir_t       w_grant_dir;
    logic [3:0] w_grant_mask;
    logic [1:0] w_head;

    // An empty slot (8'h00) never matches, whatever the key parameters are.
    always_comb begin
        w_hit  = 4'b0000;
        w_slot = 8'h00;
        for (int s = 0; s < SLOTS; s++) begin
            w_slot = keycode[8*s +: 8];
            if (w_slot != 8'h00) begin
                if (w_slot == KEY_UP)    w_hit[0] = 1'b1;
                if (w_slot == KEY_DOWN)  w_hit[1] = 1'b1;
                if (w_slot == KEY_LEFT)  w_hit[2] = 1'b1;
                if (w_slot == KEY_RIGHT) w_hit[3] = 1'b1;
            end
        end
    end

    assign w_rise  = r_held & ~r_held_d;
    assign w_event = w_rise | w_rep;

    for (genvar d = 0; d < 4; d++) begin : g_dir
        key_rep_fsm #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD),
            .CNT_W        (CNT_W)
        ) u_rep_fsm (
            .Clk   (Clk),
            .Reset (Reset),
            .i_held(r_held[d]),
            .i_rise(w_rise[d]),
            .i_tick(frame_tick),
            .o_rep (w_rep[d])
        );
    end

    assign w_pop        = move_valid & move_ready;
    assign w_grant_vld  = ~clear & (|r_pending) & (~w_full | w_pop);
    assign w_grant_dir  = prio_dir(r_pending);
    assign w_grant_mask = w_grant_vld ? (4'b0001 << w_grant_dir) : 4'b0000;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_held     <= '0;
            r_held_d   <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_last_dir <= '0;
        end else begin
            r_held   <= w_hit;
            r_held_d <= r_held;
            if (clear) begin
                r_pending  <= '0;
                r_overflow <= 1'b0;
            end else begin
                // A new event on the bit being granted this edge is not a merge.
                r_pending <= (r_pending & ~w_grant_mask) | w_event;
                if (|(r_pending & ~w_grant_mask & w_event)) r_overflow <= 1'b1;
                if (w_grant_vld) r_last_dir <= w_grant_mask;
            end
        end
    end

    move_fifo #(
        .WIDTH(2),
        .DEPTH(FIFO_DEPTH)
    ) u_move_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_flush   (clear),
        .i_push    (w_grant_vld),
        .i_push_dat(w_grant_dir),
        .o_full    (w_full),
        .i_pop     (w_pop),
        .o_empty   (w_empty),
        .o_head_dat(w_head)
    );

    assign held       = r_held;
    assign move_valid = ~w_empty;
    assign move_dir   = move_valid ? w_head : 2'b00;
    assign last_dir   = r_last_dir;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_key_move_ctrl.sv
// Scoreboard bench for key_move_ctrl: a tick-counting reference model queues expected moves,
// a negedge monitor compares DUT outputs and pops expected moves on each handshake.
module tb_key_move_ctrl;

    localparam int DELAY  = 20;
    localparam int PERIOD = 8;
    localparam int DEPTH  = 4;

    logic        Clk;
    logic        Reset;
    logic [15:0] keycode;
    logic        frame_tick;
    logic        clear;
    logic [3:0]  held;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic [3:0]  last_dir;
    logic        overflow;

    key_move_ctrl #(
        .SLOTS(2), .KEY_UP(8'h1A), .KEY_DOWN(8'h16), .KEY_LEFT(8'h04), .KEY_RIGHT(8'h07),
        .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD), .FIFO_DEPTH(DEPTH), .CNT_W(8)
    ) dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_tick(frame_tick), .clear(clear),
        .held(held), .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .last_dir(last_dir), .overflow(overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;
    int pops [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state after each edge, expressed as press/tick counts.
    logic [3:0] m_held, m_held_d, m_pend, m_last, m_hit, m_rise, m_ev, m_gmask;
    logic       m_ovf, m_pop, m_grant;
    bit         m_act [4];
    int         m_n [4];
    int         m_cnt, m_g, m_n1;
    logic [7:0] m_b;
    logic [1:0] exp_q [$];

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_held = 0; m_held_d = 0; m_pend = 0; m_last = 0; m_ovf = 0; m_cnt = 0;
            exp_q.delete();
            for (int d = 0; d < 4; d++) begin m_act[d] = 0; m_n[d] = 0; end
        end else begin
            m_hit = 0;
            for (int s = 0; s < 2; s++) begin
                m_b = keycode[8*s +: 8];
                if (m_b == 8'h1A) m_hit[0] = 1;
                if (m_b == 8'h16) m_hit[1] = 1;
                if (m_b == 8'h04) m_hit[2] = 1;
                if (m_b == 8'h07) m_hit[3] = 1;
            end
            m_rise = m_held & ~m_held_d;
            m_ev = m_rise;
            for (int d = 0; d < 4; d++) begin
                if (!m_held[d]) begin
                    m_act[d] = 0; m_n[d] = 0;
                end else if (!m_act[d]) begin
                    if (m_rise[d]) begin m_act[d] = 1; m_n[d] = 0; end
                end else if (frame_tick) begin
                    m_n1 = m_n[d] + 1;
                    // Repeats land at tick DELAY, DELAY+PERIOD, DELAY+2*PERIOD, ...
                    if (PERIOD != 0 && m_n1 >= DELAY && (m_n1 - DELAY) % PERIOD == 0) m_ev[d] = 1;
                    m_n[d] = m_n1;
                end
            end
            m_pop   = (m_cnt > 0) && move_ready;
            m_grant = !clear && (m_pend != 0) && (m_cnt < DEPTH || m_pop);
            m_g = 0;
            for (int d = 3; d >= 0; d--) if (m_pend[d]) m_g = d;
            m_gmask = m_grant ? (4'b0001 << m_g) : 4'b0000;
            if (clear) begin
                m_pend = 0; m_ovf = 0; m_cnt = 0;
                exp_q.delete();
            end else begin
                if ((m_pend & ~m_gmask & m_ev) != 0) m_ovf = 1;
                m_pend = (m_pend & ~m_gmask) | m_ev;
                m_cnt = m_cnt - int'(m_pop) + int'(m_grant);
                if (m_grant) begin
                    exp_q.push_back(2'(m_g));
                    m_last = m_gmask;
                end
            end
            m_held_d = m_held;
            m_held = m_hit;
        end
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            chk("held", held, m_held);
            chk("overflow", overflow, m_ovf);
            chk("last_dir", last_dir, m_last);
            chk("move_valid", move_valid, m_cnt > 0);
            if (move_valid && move_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL pop_unexpected: got dir %0d expected no move at %0t", move_dir, $time);
                end else begin
                    chk("move_dir", move_dir, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                pops[move_dir]++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) begin
            keycode = 16'h001A; step(2);
            keycode = 16'h0000; step(2);
        end
    endtask

    function automatic logic [7:0] rand_slot();
        case ($urandom_range(0, 7))
            0: rand_slot = 8'h1A;
            1: rand_slot = 8'h16;
            2: rand_slot = 8'h04;
            3: rand_slot = 8'h07;
            5: rand_slot = 8'($urandom);
            default: rand_slot = 8'h00;
        endcase
    endfunction

    int base;

    initial begin
        Reset = 1; keycode = 0; frame_tick = 0; clear = 0; move_ready = 0;
        for (int d = 0; d < 4; d++) pops[d] = 0;
        step(3);
        chk("rst_held", held, 4'h0);
        chk("rst_valid", move_valid, 1'b0);
        chk("rst_dir", move_dir, 2'd0);
        chk("rst_last", last_dir, 4'h0);
        chk("rst_ovf", overflow, 1'b0);
        Reset = 0;
        step(2);

        // Single-cycle press: held pulses once, move appears after the third edge.
        keycode = 16'h001A; step(1);
        chk("lat_held_e1", held, 4'b0001);
        chk("lat_valid_e1", move_valid, 1'b0);
        keycode = 16'h0000; step(1);
        chk("lat_held_e2", held, 4'b0000);
        chk("lat_valid_e2", move_valid, 1'b0);
        step(1);
        chk("lat_valid_e3", move_valid, 1'b1);
        chk("lat_dir_e3", move_dir, 2'd0);
        move_ready = 1; step(3); move_ready = 0;

        // Two keys at once queue in priority order.
        base = pops[2] + pops[3];
        keycode = 16'h0704; step(6);
        chk("lr_last_dir", last_dir, 4'b1000);
        chk("lr_head", move_dir, 2'd2);
        keycode = 16'h0000; move_ready = 1; step(4);
        chk("lr_pops", pops[2] + pops[3] - base, 2);

        // Held DOWN over 100 frame ticks.
        base = pops[1];
        keycode = 16'h0016; step(3);
        for (int i = 0; i < 100; i++) begin
            frame_tick = 1; step(1); frame_tick = 0; step(2);
        end
        keycode = 16'h0000; step(6);
        chk("repeat_down_count", pops[1] - base, 12);

        // Six presses into a stalled queue: 4 queued, 1 pending, 1 merged.
        move_ready = 0; base = pops[0];
        press_up(6); step(2);
        chk("ovf_set", overflow, 1'b1);
        move_ready = 1; step(8);
        chk("ovf_drain_count", pops[0] - base, 5);
        chk("ovf_sticky", overflow, 1'b1);
        clear = 1; step(1); clear = 0;
        chk("ovf_cleared", overflow, 1'b0);

        // Full queue + pop + pending: push on the pop edge, so a same-edge press does not merge.
        move_ready = 0; base = pops[0];
        press_up(5); step(2);
        keycode = 16'h001A; step(1);
        move_ready = 1; step(1);
        move_ready = 0; step(2);
        chk("full_pushpop_no_ovf", overflow, 1'b0);
        keycode = 16'h0000; move_ready = 1; step(8);
        chk("full_pushpop_count", pops[0] - base, 6);

        // Reset mid-operation with DOWN in DELAY.
        move_ready = 0;
        press_up(3);
        keycode = 16'h0016; step(4);
        Reset = 1; #1;
        chk("mid_rst_held", held, 4'h0);
        chk("mid_rst_valid", move_valid, 1'b0);
        chk("mid_rst_dir", move_dir, 2'd0);
        chk("mid_rst_last", last_dir, 4'h0);
        chk("mid_rst_ovf", overflow, 1'b0);
        step(2);
        Reset = 0; step(4);
        chk("post_rst_held", held, 4'b0010);
        chk("post_rst_valid", move_valid, 1'b1);
        chk("post_rst_dir", move_dir, 2'd1);
        keycode = 16'h0000; move_ready = 1; step(4);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 47) == 0) keycode = {rand_slot(), rand_slot()};
            frame_tick = ($urandom_range(0, 1) == 0);
            move_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 299) == 0);
            step(1);
        end
        keycode = 0; frame_tick = 0; clear = 0; move_ready = 1;
        step(12);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
